// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronizes and deglitches an async input, emits edge strobes and a loss-of-signal flag.
// Define PULSE_CONDITIONER_GLITCH_CNT_EN to build the saturating rejected-glitch counter.
module pulse_conditioner #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          FILT_LEN       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic        sig_clean,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        sig_lost,
    output logic [15:0] glitch_cnt
);
    localparam logic [7:0]  FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             stab_q, stab_d;
    logic [31:0]            idle_q, idle_d;
    logic                   clean_q, rise_q, fall_q, lost_q, lost_d;
    logic                   sig_sync, differ, accept;

    assign sig_sync = sync_q[SYNC_STAGES-1];
    assign differ   = sig_sync != clean_q;
    assign accept   = differ && stab_q == FILT_LAST;

    // idle count is zero in the strobe cycle, so loss asserts TIMEOUT_CYCLES edges after the accepting edge
    always_comb begin
        stab_d = (differ && !accept) ? stab_q + 8'd1 : 8'd0;
        idle_d = accept ? 32'd0 : (idle_q == IDLE_LAST) ? idle_q : idle_q + 32'd1;
        lost_d = accept ? 1'b0 : (idle_q == IDLE_LAST) | lost_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            stab_q  <= '0;
            idle_q  <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            stab_q  <= stab_d;
            idle_q  <= idle_d;
            clean_q <= accept ? sig_sync : clean_q;
            rise_q  <= accept && sig_sync;
            fall_q  <= accept && !sig_sync;
            lost_q  <= lost_d;
        end
    end

`ifdef PULSE_CONDITIONER_GLITCH_CNT_EN
    logic [15:0] glitch_q;
    logic        glitch_hit;

    // a partial run that collapses back to the accepted level is a rejected glitch
    assign glitch_hit = !differ && stab_q != 8'd0;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) glitch_q <= '0;
        else        glitch_q <= (glitch_hit && glitch_q != 16'hFFFF) ? glitch_q + 16'd1 : glitch_q;
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = 16'h0000;
`endif

    assign sig_clean  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign sig_lost   = lost_q;
endmodule

// File: tb/tb_pulse_conditioner.sv
// tb_pulse_conditioner: directed and random stimulus checked against a sample-window reference model.
module tb_pulse_conditioner;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TOUT = 100;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sig_in  = 1'b0;
    logic        sig_clean, rise_pulse, fall_pulse, sig_lost;
    logic [15:0] glitch_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic inq[$];
    logic sq[$];
    logic m_clean, m_rise, m_fall;
    int   m_since, m_glitch;

    pulse_conditioner #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sig_in(sig_in), .sig_clean(sig_clean),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .sig_lost(sig_lost), .glitch_cnt(glitch_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inq.delete();
        sq.delete();
        m_clean = 0; m_rise = 0; m_fall = 0; m_since = 0; m_glitch = 0;
    endtask

    // sig_sync seen at an edge is the input sampled SYNC edges earlier; a level is accepted
    // once the last FILT synchronized samples all differ from the current clean level
    task automatic model_edge(input logic v);
        logic s, acc, gl;
        s = (inq.size() >= SYNC) ? inq[inq.size() - SYNC] : 1'b0;
        inq.push_back(v);
        sq.push_back(s);
        if (inq.size() > 64) void'(inq.pop_front());
        if (sq.size() > 64) void'(sq.pop_front());
        acc = sq.size() >= FILT;
        for (int i = 0; i < FILT; i++)
            if (acc && sq[sq.size() - 1 - i] == m_clean) acc = 0;
        gl = (s == m_clean) && sq.size() >= 2 && sq[sq.size() - 2] != m_clean;
        if (gl && m_glitch < 65535) m_glitch++;
        m_rise = acc && s;
        m_fall = acc && !s;
        if (acc) m_clean = s;
        m_since = acc ? 0 : (m_since < 1000000 ? m_since + 1 : m_since);
    endtask

    function automatic logic [15:0] exp_glitch();
`ifdef PULSE_CONDITIONER_GLITCH_CNT_EN
        return 16'(m_glitch);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_all();
        chk("sig_clean", 32'(sig_clean), 32'(m_clean));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        chk("sig_lost", 32'(sig_lost), 32'(m_since >= TOUT));
        chk("glitch_cnt", 32'(glitch_cnt), 32'(exp_glitch()));
    endtask

    task automatic step(input logic v);
        sig_in = v;
        @(posedge sys_clk);
        model_edge(v);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clean"}, 32'(sig_clean), 0);
        chk({tag, "_rise"}, 32'(rise_pulse), 0);
        chk({tag, "_fall"}, 32'(fall_pulse), 0);
        chk({tag, "_lost"}, 32'(sig_lost), 0);
        chk({tag, "_glitch"}, 32'(glitch_cnt), 0);
    endtask

    initial begin
        int n, rises, falls;
        logic lvl;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 check_zero("reset");
        @(negedge sys_clk) rst_n = 1'b1;

        // held rising level: accepted on the 6th edge, strobe lasts one cycle
        n = 0;
        do begin step(1); n++; end while (!rise_pulse && n < 20);
        chk("rise_latency", 32'(n), 6);
        step(1);
        chk("rise_one_cycle", 32'(rise_pulse), 0);
        repeat (10) step(1);
        repeat (10) step(0);

        // 3-cycle pulse is rejected
        repeat (3) step(1);
        repeat (10) step(0);
        chk("short_pulse_clean", 32'(sig_clean), 0);

        // 100-cycle square wave: 50 rises and 50 falls per 50 periods
        rises = 0; falls = 0;
        for (int p = 0; p < 60; p++)
            for (int c = 0; c < 100; c++) begin
                step(c < 50);
                if (p >= 10) begin rises += int'(rise_pulse); falls += int'(fall_pulse); end
            end
        chk("square_rises", 32'(rises), 50);
        chk("square_falls", 32'(falls), 50);
        repeat (10) step(0);

        // loss after TOUT idle cycles, cleared in the strobe cycle of the next edge
        n = 0;
        do begin step(1); n++; end while (!rise_pulse && n < 20);
        chk("timeout_rise_seen", 32'(rise_pulse), 1);
        n = 0;
        do begin step(1); n++; end while (!sig_lost && n < 300);
        chk("timeout_cycles", 32'(n), TOUT);
        n = 0;
        do begin step(0); n++; end while (!fall_pulse && n < 20);
        chk("lost_clear_fall", 32'(fall_pulse), 1);
        chk("lost_clear_same_cycle", 32'(sig_lost), 0);

        // random run lengths around the filter threshold
        lvl = 0;
        for (int r = 0; r < 400; r++) begin
            lvl = ($urandom_range(0, 3) == 0) ? lvl : ~lvl;
            n = $urandom_range(1, 7);
            repeat (n) step(lvl);
        end
        repeat (10) step(0);

        // burst of single-cycle glitches
        for (int g = 0; g < 500; g++) begin
            step(1);
            repeat (3) step(0);
        end
        chk("glitch_burst", 32'(glitch_cnt), 32'(exp_glitch()));

        // reset mid-filter discards the partial count
        repeat (4) step(1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge sys_clk);
        #3 rst_n = 1'b1;
        n = 0;
        do begin step(1); n++; end while (!rise_pulse && n < 20);
        chk("post_reset_latency", 32'(n), 6);
        step(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
